unified_mem_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each memory transaction through a request/ack handshake and returns data to the winning requester.
- Raises a pipeline stall while any requester waits; that stall drives the PC write enable and the IF/ID and ID/EX hold logic.
- Flags memories that never acknowledge.

---
 rtl/unified_mem_arbiter_pkg.sv | 13 +
 rtl/unified_mem_arbiter_timer.sv | 33 +++
 rtl/unified_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory arbiter: FSM state encodings and
// the default transaction timeout.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/unified_mem_arbiter_timer.sv
// Watchdog for one memory transaction: cleared at launch, counts busy cycles
// without an acknowledge and flags expiry once the limit is reached.
module mem_arb_timer
    import unified_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    // Holds at the limit so expiry stays visible until the next launch clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction
// fetch and load/store, returning data to the winner and stalling the pipeline.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              error_o,
    output logic [31:0]       stall_cnt_o
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_ready;
    logic              r_dm_ready;
    logic              r_if_flush;
    logic              r_error;
    logic [31:0]       r_stall_cnt;

    logic              w_dm_pend;
    logic              w_if_pend;
    logic              w_busy;
    logic              w_expire;
    logic              w_done;
    logic              w_launch_dm;
    logic              w_launch_if;
    logic              w_stall;
    logic [DATA_W-1:0] w_rdata;

    // A requester whose ready is pulsing this cycle is not pending, which
    // forces it back through arbitration before it can be granted again.
    assign w_dm_pend = (dm_read_i | dm_write_i) & ~r_dm_ready;
    assign w_if_pend = if_req_i & ~r_if_ready;
    assign w_busy    = (r_state != IDLE);
    assign w_done    = w_busy & (mem_ack_i | w_expire);
    assign w_rdata   = mem_ack_i ? mem_rdata_i : '0;
    assign w_stall   = rst_i & ((if_req_i & ~r_if_ready) |
                                ((dm_read_i | dm_write_i) & ~r_dm_ready));

    mem_arb_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_clear  (w_launch_dm | w_launch_if),
        .i_enable (w_busy & ~mem_ack_i),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch_dm = 1'b0;
        w_launch_if = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_dm_pend) begin
                    w_state_nxt = DM_BUSY;
                    w_launch_dm = 1'b1;
                end else if (w_if_pend) begin
                    w_state_nxt = IF_BUSY;
                    w_launch_if = 1'b1;
                end
            end
            DM_BUSY: begin
                if (w_done) begin
                    if (w_if_pend) begin
                        w_state_nxt = IF_BUSY;
                        w_launch_if = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            IF_BUSY: begin
                if (w_done) begin
                    if (w_dm_pend) begin
                        w_state_nxt = DM_BUSY;
                        w_launch_dm = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_flush  <= 1'b0;
            r_error     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;

            if (w_launch_dm) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= dm_write_i;
                r_mem_addr  <= dm_addr_i;
                r_mem_wdata <= dm_wdata_i;
            end else if (w_launch_if) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr_i;
                r_mem_wdata <= '0;
            end else if (w_done) begin
                r_mem_req   <= 1'b0;
                r_mem_we    <= 1'b0;
            end

            // Stores complete with a ready pulse but leave the load data alone.
            if (w_done && (r_state == DM_BUSY)) begin
                r_dm_ready <= 1'b1;
                if (!r_mem_we) begin
                    r_dm_rdata <= w_rdata;
                end
            end

            if (w_done && (r_state == IF_BUSY) && if_req_i && !r_if_flush) begin
                r_if_ready <= 1'b1;
                r_if_rdata <= w_rdata;
            end

            // A fetch withdrawn mid-flight still drains the memory but gets no reply.
            if (w_launch_if) begin
                r_if_flush <= 1'b0;
            end else if ((r_state == IF_BUSY) && !if_req_i) begin
                r_if_flush <= 1'b1;
            end

            if (w_done && !mem_ack_i) begin
                r_error <= 1'b1;
            end

            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign if_rdata_o  = r_if_rdata;
    assign if_ready_o  = r_if_ready;
    assign dm_rdata_o  = r_dm_rdata;
    assign dm_ready_o  = r_dm_ready;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign stall_o     = w_stall;
    assign error_o     = r_error;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed scenarios push expected
// ready pulses (data and cycle) into queues that a monitor pops and checks.
module tb_unified_mem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        dm_read_i = 1'b0;
    logic        dm_write_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        stall_o;
    logic        error_o;
    logic [31:0] stall_cnt_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   lat      = 0;
    int   mem_cnt  = 0;
    bit   noack    = 1'b0;
    bit   idle_ack = 1'b0;
    int   t0;
    exp_t if_q[$];
    exp_t dm_q[$];
    exp_t mon_e;

    unified_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .dm_read_i   (dm_read_i),
        .dm_write_i  (dm_write_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o),
        .error_o     (error_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push_if(input logic [31:0] d, input int c);
        exp_t e;
        e.rdata = d;
        e.cyc   = c;
        if_q.push_back(e);
    endtask

    task automatic push_dm(input logic [31:0] d, input int c);
        exp_t e;
        e.rdata = d;
        e.cyc   = c;
        dm_q.push_back(e);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h00A0_0093;
            32'h20:  return 32'h1111_2222;
            32'h80:  return 32'h3333_4444;
            default: return 32'hCAFE_F00D;
        endcase
    endfunction

    // Memory model: acknowledges a request after `lat` extra wait cycles.
    always begin
        @(posedge clk_i);
        #2;
        if (mem_req_o && !noack) begin
            if (mem_cnt >= lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_rd(mem_addr_o);
                mem_cnt     = 0;
            end else begin
                mem_ack_i = 1'b0;
                mem_cnt++;
            end
        end else begin
            mem_ack_i   = idle_ack;
            mem_rdata_i = 32'hBAD0_BAD0;
            mem_cnt     = 0;
        end
    end

    // Monitor: every ready pulse must match the head of its queue.
    always begin
        @(posedge clk_i);
        #1;
        if (if_ready_o) begin
            if (if_q.size() == 0) begin
                chk("if_unexpected_pulse", 32'(if_ready_o), 32'd0);
            end else begin
                mon_e = if_q.pop_front();
                chk("if_rdata", if_rdata_o, mon_e.rdata);
                chk("if_ready_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        if (dm_ready_o) begin
            if (dm_q.size() == 0) begin
                chk("dm_unexpected_pulse", 32'(dm_ready_o), 32'd0);
            end else begin
                mon_e = dm_q.pop_front();
                chk("dm_rdata", dm_rdata_o, mon_e.rdata);
                chk("dm_ready_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst_i = 1'b0;
        #2;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_if_ready", 32'(if_ready_o), 32'd0);
        chk("rst_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        chk("rst_dm_rdata", dm_rdata_o, 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        wait_neg(2);
        rst_i = 1'b1;
        wait_neg(1);

        // Zero-wait fetch
        lat = 0;
        if_req_i = 1'b1;
        if_addr_i = 32'h10;
        t0 = cyc + 1;
        push_if(32'h00A0_0093, t0 + 1);
        #1 chk("zw_stall_t", 32'(stall_o), 32'd1);
        wait_neg(1);
        chk("zw_mem_req", 32'(mem_req_o), 32'd1);
        chk("zw_mem_addr", mem_addr_o, 32'h10);
        chk("zw_mem_we", 32'(mem_we_o), 32'd0);
        chk("zw_stall_t1", 32'(stall_o), 32'd1);
        wait_neg(1);
        chk("zw_stall_ready", 32'(stall_o), 32'd0);
        wait_neg(1);
        chk("zw_no_regrant", 32'(mem_req_o), 32'd0);
        if_req_i = 1'b0;
        chk("zw_stall_cnt", stall_cnt_o, 32'd2);
        wait_neg(1);

        // Contention: DM first, IF follows with no idle gap
        lat = 3;
        dm_read_i = 1'b1;
        dm_addr_i = 32'h80;
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        t0 = cyc + 1;
        push_dm(32'h3333_4444, t0 + 4);
        push_if(32'h1111_2222, t0 + 8);
        wait_neg(1);
        chk("ct_dm_first_addr", mem_addr_o, 32'h80);
        chk("ct_dm_first_we", 32'(mem_we_o), 32'd0);
        wait_neg(4);
        dm_read_i = 1'b0;
        chk("ct_if_launch_req", 32'(mem_req_o), 32'd1);
        chk("ct_if_launch_addr", mem_addr_o, 32'h20);
        wait_neg(4);
        if_req_i = 1'b0;
        chk("ct_idle_req", 32'(mem_req_o), 32'd0);
        wait_neg(1);

        // Store: dm_rdata must keep the previous load value
        lat = 1;
        dm_write_i = 1'b1;
        dm_addr_i  = 32'h40;
        dm_wdata_i = 32'hDEAD_BEEF;
        t0 = cyc + 1;
        push_dm(32'h3333_4444, t0 + 2);
        for (int i = 0; i < 2; i++) begin
            wait_neg(1);
            chk("st_we", 32'(mem_we_o), 32'd1);
            chk("st_addr", mem_addr_o, 32'h40);
            chk("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        end
        wait_neg(1);
        dm_write_i = 1'b0;
        chk("st_req_drop", 32'(mem_req_o), 32'd0);
        chk("st_stall_cnt", stall_cnt_o, 32'd14);
        wait_neg(1);

        // Fetch flush: memory completes, no if_ready pulse
        lat = 3;
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        wait_neg(2);
        if_req_i = 1'b0;
        chk("fl_busy_req", 32'(mem_req_o), 32'd1);
        wait_neg(3);
        chk("fl_done_req", 32'(mem_req_o), 32'd0);
        wait_neg(1);
        chk("fl_idle_req", 32'(mem_req_o), 32'd0);

        // Ack while idle is ignored
        idle_ack = 1'b1;
        wait_neg(3);
        idle_ack = 1'b0;
        chk("ia_req", 32'(mem_req_o), 32'd0);
        chk("ia_stall_cnt", stall_cnt_o, 32'd16);
        wait_neg(1);

        // Timeout after 4 busy cycles without ack
        noack = 1'b1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        t0 = cyc + 1;
        push_if(32'h0, t0 + 5);
        wait_neg(5);
        chk("to_err_before", 32'(error_o), 32'd0);
        chk("to_req_before", 32'(mem_req_o), 32'd1);
        wait_neg(1);
        if_req_i = 1'b0;
        chk("to_err_set", 32'(error_o), 32'd1);
        chk("to_req_drop", 32'(mem_req_o), 32'd0);
        noack = 1'b0;
        wait_neg(1);

        // Error stays set across a later good transaction
        lat = 0;
        dm_read_i = 1'b1;
        dm_addr_i = 32'h80;
        t0 = cyc + 1;
        push_dm(32'h3333_4444, t0 + 1);
        wait_neg(2);
        dm_read_i = 1'b0;
        chk("to_err_sticky", 32'(error_o), 32'd1);
        chk("to_stall_cnt", stall_cnt_o, 32'd24);
        wait_neg(1);

        // Asynchronous reset during DM_BUSY
        lat = 3;
        dm_read_i = 1'b1;
        dm_addr_i = 32'h20;
        wait_neg(2);
        chk("ar_busy_req", 32'(mem_req_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("ar_req", 32'(mem_req_o), 32'd0);
        chk("ar_stall_cnt", stall_cnt_o, 32'd0);
        chk("ar_error", 32'(error_o), 32'd0);
        chk("ar_dm_rdata", dm_rdata_o, 32'd0);
        chk("ar_stall", 32'(stall_o), 32'd0);
        dm_read_i = 1'b0;
        wait_neg(2);
        rst_i = 1'b1;
        wait_neg(1);
        lat = 0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        t0 = cyc + 1;
        push_if(32'h00A0_0093, t0 + 1);
        wait_neg(2);
        if_req_i = 1'b0;
        chk("ar_post_error", 32'(error_o), 32'd0);
        chk("ar_post_stall_cnt", stall_cnt_o, 32'd2);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && (if_q.size() + dm_q.size()) > 0; i++) begin
            wait_neg(1);
        end
        chk("if_missing_pulses", 32'(if_q.size()), 32'd0);
        chk("dm_missing_pulses", 32'(dm_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
